// File: rtl/bsp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bsp_pkg
// Description : Shared constants, FSM encoding and shift reduction for the
//               BSP permutation feeder stages.
// Revision    : 1.0 - initial release
// ============================================================================
package bsp_pkg;

    localparam int CHECK_PARALLELISM = 85;
    localparam int SHIFT_WIDTH       = 7;
    localparam int SW_WIDTH          = 4;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    // The raw range 0..127 stays below twice the circulant size, so one
    // conditional subtraction is a complete modulo.
    function automatic logic [SHIFT_WIDTH-1:0] shift_mod85(input logic [SHIFT_WIDTH-1:0] raw);
        if (int'(raw) < CHECK_PARALLELISM) begin
            return raw;
        end
        return raw - SHIFT_WIDTH'(CHECK_PARALLELISM);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bsp_valid_delay.sv
`default_nettype none
// ============================================================================
// Module      : bsp_valid_delay
// Description : DEPTH-stage shift register with async active-low clear, used
//               to align side-band data with the permutation pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
module bsp_valid_delay #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [DEPTH-1:0][WIDTH-1:0] r_stage;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stage <= '0;
        end else begin
            r_stage[0] <= i_data;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_data = r_stage[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/bsp_shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : bsp_shift_sequencer
// Description : Issues a run-time loaded table of (shift, switch) entries to
//               the 85-bit permutation wrapper with a latency-aligned valid.
// Revision    : 1.0 - initial release
// ============================================================================
module bsp_shift_sequencer
    import bsp_pkg::*;
#(
    parameter int ENTRY_NUM    = 16,
    parameter int ADDR_WIDTH   = 4,
    parameter int PIPE_LATENCY = 1
) (
    input  logic                   read_clk,
    input  logic                   rstn,
    input  logic                   cfg_we,
    input  logic [ADDR_WIDTH-1:0]  cfg_addr,
    input  logic [SHIFT_WIDTH-1:0] cfg_shift,
    input  logic [SW_WIDTH-1:0]    cfg_sw,
    input  logic [ADDR_WIDTH:0]    cfg_entry_cnt,
    output logic                   cfg_err,
    input  logic                   start,
    input  logic                   ready,
    output logic                   busy,
    output logic                   done,
    output logic [SHIFT_WIDTH-1:0] shift_factor,
    output logic [SW_WIDTH-1:0]    sw_in,
    output logic                   perm_valid,
    output logic [ADDR_WIDTH-1:0]  perm_idx
);

    localparam int c_DRAIN_W = 3;

    logic [SHIFT_WIDTH-1:0] r_tbl_shift [ENTRY_NUM];
    logic [SW_WIDTH-1:0]    r_tbl_sw    [ENTRY_NUM];

    logic [1:0]             r_state;
    logic [ADDR_WIDTH:0]    r_cnt;
    logic [ADDR_WIDTH-1:0]  r_idx;
    logic [c_DRAIN_W-1:0]   r_drain;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_cfg_err;
    logic [SHIFT_WIDTH-1:0] r_shift;
    logic [SW_WIDTH-1:0]    r_sw;

    logic                   w_addr_ok;
    logic                   w_wr_en;
    logic                   w_fire;
    logic                   w_last;
    logic [ADDR_WIDTH-1:0]  w_idx_nxt;
    logic [ADDR_WIDTH:0]    w_dly_q;

    assign w_addr_ok = int'(cfg_addr) < ENTRY_NUM;
    assign w_wr_en   = cfg_we && (r_state == c_IDLE) && w_addr_ok;
    assign w_fire    = (r_state == c_ISSUE) && ready;
    assign w_last    = ({1'b0, r_idx} == (r_cnt - (ADDR_WIDTH+1)'(1)));
    assign w_idx_nxt = r_idx + ADDR_WIDTH'(1);

    // Table contents deliberately survive reset.
    always_ff @(posedge read_clk) begin
        if (w_wr_en) begin
            r_tbl_shift[cfg_addr] <= shift_mod85(cfg_shift);
            r_tbl_sw[cfg_addr]    <= cfg_sw;
        end
    end

    always_ff @(posedge read_clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= c_IDLE;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_drain   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_cfg_err <= 1'b0;
            r_shift   <= '0;
            r_sw      <= '0;
        end else begin
            r_done    <= 1'b0;
            r_cfg_err <= cfg_we && !w_wr_en;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_cnt  <= cfg_entry_cnt;
                        r_idx  <= '0;
                        r_busy <= 1'b1;
                        if (cfg_entry_cnt == '0) begin
                            r_state <= c_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= c_ISSUE;
                            r_shift <= r_tbl_shift[0];
                            r_sw    <= r_tbl_sw[0];
                        end
                    end
                end
                c_ISSUE: begin
                    // Output registers hold while stalled so the wrapper sees a stable entry.
                    if (ready) begin
                        r_idx <= w_idx_nxt;
                        if (w_last) begin
                            r_state <= c_DRAIN;
                            r_drain <= c_DRAIN_W'(PIPE_LATENCY);
                            r_shift <= '0;
                            r_sw    <= '0;
                        end else begin
                            r_shift <= r_tbl_shift[w_idx_nxt];
                            r_sw    <= r_tbl_sw[w_idx_nxt];
                        end
                    end
                end
                c_DRAIN: begin
                    r_drain <= r_drain - c_DRAIN_W'(1);
                    if (r_drain == c_DRAIN_W'(1)) begin
                        r_state <= c_DONE;
                        r_done  <= 1'b1;
                    end
                end
                c_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    bsp_valid_delay #(
        .DEPTH (PIPE_LATENCY),
        .WIDTH (ADDR_WIDTH + 1)
    ) u_valid_delay (
        .clk    (read_clk),
        .rst_n  (rstn),
        .i_data ({w_fire, r_idx}),
        .o_data (w_dly_q)
    );

    assign perm_valid   = w_dly_q[ADDR_WIDTH];
    assign perm_idx     = w_dly_q[ADDR_WIDTH-1:0];
    assign busy         = r_busy;
    assign done         = r_done;
    assign cfg_err      = r_cfg_err;
    assign shift_factor = r_shift;
    assign sw_in        = r_sw;

endmodule
`default_nettype wire

// File: tb/tb_bsp_shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_bsp_shift_sequencer
// Description : Directed self-checking bench for bsp_shift_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_bsp_shift_sequencer;

    localparam int PL = 2;
    localparam int AW = 4;
    localparam int NOBS = 32;

    logic          read_clk = 1'b0;
    logic          rstn = 1'b0;
    logic          cfg_we = 1'b0;
    logic [AW-1:0] cfg_addr = '0;
    logic [6:0]    cfg_shift = '0;
    logic [3:0]    cfg_sw = '0;
    logic [AW:0]   cfg_entry_cnt = '0;
    logic          cfg_err;
    logic          start = 1'b0;
    logic          ready = 1'b1;
    logic          busy;
    logic          done;
    logic [6:0]    shift_factor;
    logic [3:0]    sw_in;
    logic          perm_valid;
    logic [AW-1:0] perm_idx;

    always #5 read_clk = ~read_clk;

    bsp_shift_sequencer #(
        .ENTRY_NUM    (16),
        .ADDR_WIDTH   (AW),
        .PIPE_LATENCY (PL)
    ) dut (
        .read_clk      (read_clk),
        .rstn          (rstn),
        .cfg_we        (cfg_we),
        .cfg_addr      (cfg_addr),
        .cfg_shift     (cfg_shift),
        .cfg_sw        (cfg_sw),
        .cfg_entry_cnt (cfg_entry_cnt),
        .cfg_err       (cfg_err),
        .start         (start),
        .ready         (ready),
        .busy          (busy),
        .done          (done),
        .shift_factor  (shift_factor),
        .sw_in         (sw_in),
        .perm_valid    (perm_valid),
        .perm_idx      (perm_idx)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [6:0]    o_sf   [NOBS];
    logic [3:0]    o_sw   [NOBS];
    logic          o_pv   [NOBS];
    logic [AW-1:0] o_pi   [NOBS];
    logic          o_done [NOBS];
    logic          o_busy [NOBS];
    logic          rdy_pat[NOBS];

    task automatic step();
        @(negedge read_clk);
    endtask

    task automatic wr(input int a, input int s, input int w);
        cfg_we    = 1'b1;
        cfg_addr  = AW'(a);
        cfg_shift = 7'(s);
        cfg_sw    = 4'(w);
        step();
        cfg_we = 1'b0;
    endtask

    task automatic ready_all();
        for (int i = 0; i < NOBS; i++) rdy_pat[i] = 1'b1;
    endtask

    // Start a pass and record outputs after each edge; rdy_pat[c] drives the cycle observed as c.
    task automatic run_pass(input int cnt, input int ncyc);
        cfg_entry_cnt = (AW+1)'(cnt);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            o_sf[c]   = shift_factor;
            o_sw[c]   = sw_in;
            o_pv[c]   = perm_valid;
            o_pi[c]   = perm_idx;
            o_done[c] = done;
            o_busy[c] = busy;
            ready = rdy_pat[c];
            step();
        end
        ready = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        step();
        step();
        n_checks++;
        if ({busy, done, cfg_err, perm_valid} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got busy/done/err/pv=%b, want 0000", {busy, done, cfg_err, perm_valid});
        end
        n_checks++;
        if ({shift_factor, sw_in, perm_idx} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_data: got sf=%0d sw=%0d idx=%0d, want all 0", shift_factor, sw_in, perm_idx);
        end
        rstn = 1'b1;
        step();
    endtask

    task automatic test_basic_issue();
        int exp_sf[3] = '{5, 84, 15};
        int exp_sw[3] = '{1, 2, 4};
        int npv;
        wr(0, 5, 1);
        n_checks++;
        if (cfg_err !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_write_err: got %b, want 0", cfg_err);
        end
        wr(1, 84, 2);
        wr(2, 100, 4);
        ready_all();
        run_pass(3, 10);
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (o_sf[k] !== 7'(exp_sf[k]) || o_sw[k] !== 4'(exp_sw[k])) begin
                n_fail++;
                $display("FAIL basic_issue[%0d]: got sf=%0d sw=%0d, want sf=%0d sw=%0d", k, o_sf[k], o_sw[k], exp_sf[k], exp_sw[k]);
            end
            n_checks++;
            if (o_pv[k+PL] !== 1'b1 || o_pi[k+PL] !== AW'(k)) begin
                n_fail++;
                $display("FAIL basic_valid[%0d]: got pv=%b idx=%0d, want pv=1 idx=%0d", k, o_pv[k+PL], o_pi[k+PL], k);
            end
        end
        n_checks++;
        if (o_sf[3] !== 7'd0 || o_sw[3] !== 4'd0) begin
            n_fail++;
            $display("FAIL basic_drain_zero: got sf=%0d sw=%0d, want 0 0", o_sf[3], o_sw[3]);
        end
        npv = 0;
        for (int c = 0; c < 10; c++) if (o_pv[c] === 1'b1) npv++;
        n_checks++;
        if (npv != 3) begin
            n_fail++;
            $display("FAIL basic_valid_count: got %0d, want 3", npv);
        end
        n_checks++;
        if (o_done[3+PL] !== 1'b1 || o_done[2+PL] !== 1'b0 || o_done[4+PL] !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done_timing: got done[%0d..%0d]=%b%b%b, want 010", 2+PL, 4+PL, o_done[2+PL], o_done[3+PL], o_done[4+PL]);
        end
        n_checks++;
        if (o_busy[0] !== 1'b1 || o_busy[3+PL] !== 1'b1 || o_busy[4+PL] !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_busy: got first=%b at_done=%b after=%b, want 1 1 0", o_busy[0], o_busy[3+PL], o_busy[4+PL]);
        end
    endtask

    task automatic test_stall();
        int exp_sf[7] = '{5, 84, 84, 84, 84, 15, 0};
        int vidx[$];
        ready_all();
        rdy_pat[1] = 1'b0;
        rdy_pat[2] = 1'b0;
        rdy_pat[3] = 1'b0;
        run_pass(3, 12);
        ready_all();
        for (int c = 0; c < 7; c++) begin
            n_checks++;
            if (o_sf[c] !== 7'(exp_sf[c])) begin
                n_fail++;
                $display("FAIL stall_sf[%0d]: got %0d, want %0d", c, o_sf[c], exp_sf[c]);
            end
        end
        for (int c = 0; c < 12; c++) if (o_pv[c] === 1'b1) vidx.push_back(int'(o_pi[c]));
        n_checks++;
        if (vidx.size() != 3) begin
            n_fail++;
            $display("FAIL stall_valid_count: got %0d, want 3", vidx.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (vidx[k] != k) begin
                    n_fail++;
                    $display("FAIL stall_valid_order[%0d]: got idx %0d, want %0d", k, vidx[k], k);
                end
            end
        end
        n_checks++;
        if (o_pv[2] !== 1'b1 || o_pv[6] !== 1'b1 || o_pv[7] !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_valid_timing: got pv[2,6,7]=%b%b%b, want 111", o_pv[2], o_pv[6], o_pv[7]);
        end
        n_checks++;
        if (o_done[8] !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_done: got done[8]=%b, want 1", o_done[8]);
        end
    endtask

    task automatic test_zero_cnt();
        int npv;
        int sf_or;
        ready_all();
        run_pass(0, 6);
        n_checks++;
        if (o_busy[0] !== 1'b1 || o_done[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_first_cycle: got busy=%b done=%b, want 1 1", o_busy[0], o_done[0]);
        end
        n_checks++;
        if (o_busy[1] !== 1'b0 || o_done[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_second_cycle: got busy=%b done=%b, want 0 0", o_busy[1], o_done[1]);
        end
        npv = 0;
        sf_or = 0;
        for (int c = 0; c < 6; c++) begin
            if (o_pv[c] === 1'b1) npv++;
            sf_or = sf_or | int'(o_sf[c]);
        end
        n_checks++;
        if (npv != 0 || sf_or != 0) begin
            n_fail++;
            $display("FAIL zero_quiet: got %0d valids, sf OR=%0d, want 0 0", npv, sf_or);
        end
    endtask

    task automatic test_cfg_err();
        int guard;
        ready_all();
        cfg_entry_cnt = 5'd3;
        start = 1'b1;
        step();
        start = 1'b0;
        cfg_we    = 1'b1;
        cfg_addr  = '0;
        cfg_shift = 7'd9;
        cfg_sw    = 4'd7;
        step();
        cfg_we = 1'b0;
        n_checks++;
        if (cfg_err !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_write_err: got %b, want 1", cfg_err);
        end
        step();
        n_checks++;
        if (cfg_err !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_write_err_pulse: got %b, want 0", cfg_err);
        end
        guard = 0;
        while (busy === 1'b1 && guard < 50) begin
            step();
            guard++;
        end
        n_checks++;
        if (guard >= 50) begin
            n_fail++;
            $display("FAIL busy_write_idle_wait: busy still %b after %0d cycles, want 0", busy, guard);
        end
        run_pass(1, 6);
        n_checks++;
        if (o_sf[0] !== 7'd5 || o_sw[0] !== 4'd1) begin
            n_fail++;
            $display("FAIL busy_write_table: got sf=%0d sw=%0d, want 5 1", o_sf[0], o_sw[0]);
        end
    endtask

    task automatic test_reset_mid_pass();
        int bad_pv;
        int bad_done;
        ready_all();
        cfg_entry_cnt = 5'd3;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        n_checks++;
        if (shift_factor !== 7'd84 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_pre: got sf=%0d busy=%b, want 84 1", shift_factor, busy);
        end
        #2 rstn = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, perm_valid, cfg_err} !== 4'b0000 || shift_factor !== 7'd0 || sw_in !== 4'd0 || perm_idx !== '0) begin
            n_fail++;
            $display("FAIL midreset_async: got busy=%b done=%b pv=%b sf=%0d sw=%0d idx=%0d, want all 0",
                     busy, done, perm_valid, shift_factor, sw_in, perm_idx);
        end
        step();
        rstn = 1'b1;
        bad_pv = 0;
        bad_done = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (perm_valid !== 1'b0) bad_pv++;
            if (done !== 1'b0 || busy !== 1'b0) bad_done++;
        end
        n_checks++;
        if (bad_pv != 0 || bad_done != 0) begin
            n_fail++;
            $display("FAIL midreset_quiet: got %0d valid and %0d busy/done cycles, want 0 0", bad_pv, bad_done);
        end
        run_pass(3, 8);
        n_checks++;
        if (o_sf[0] !== 7'd5 || o_sf[1] !== 7'd84 || o_sf[2] !== 7'd15) begin
            n_fail++;
            $display("FAIL midreset_retained: got %0d %0d %0d, want 5 84 15", o_sf[0], o_sf[1], o_sf[2]);
        end
    endtask

    task automatic test_shift_127();
        ready_all();
        wr(0, 127, 1);
        run_pass(1, 6);
        n_checks++;
        if (o_sf[0] !== 7'd42 || o_sw[0] !== 4'd1) begin
            n_fail++;
            $display("FAIL shift127: got sf=%0d sw=%0d, want 42 1", o_sf[0], o_sw[0]);
        end
    endtask

    // Covers every raw value 0..127 in batches of 16 full-table passes.
    task automatic test_shift_range();
        int raw;
        int exp;
        ready_all();
        for (int b = 0; b < 8; b++) begin
            for (int i = 0; i < 16; i++) wr(i, b*16 + i, i);
            run_pass(16, 16 + PL + 3);
            for (int i = 0; i < 16; i++) begin
                raw = b*16 + i;
                exp = (raw < 85) ? raw : raw - 85;
                n_checks++;
                if (o_sf[i] !== 7'(exp) || o_sw[i] !== 4'(i)) begin
                    n_fail++;
                    $display("FAIL shift_range raw=%0d: got sf=%0d sw=%0d, want %0d %0d", raw, o_sf[i], o_sw[i], exp, i);
                end
            end
            n_checks++;
            if (o_done[16+PL] !== 1'b1) begin
                n_fail++;
                $display("FAIL shift_range_done batch %0d: got %b, want 1", b, o_done[16+PL]);
            end
        end
    endtask

    initial begin
        ready_all();
        test_reset();
        test_basic_issue();
        test_stall();
        test_zero_cnt();
        test_cfg_err();
        test_reset_mid_pass();
        test_shift_127();
        test_shift_range();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
